univ_shift_reg: RTL and testbench

//  Parametrised universal shift register built from per-bit D-type stages with

---
 rtl/univ_shift_reg.sv | 135 +++++++++++++
 tb/tb_univ_shift_reg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - parametrised universal shift register with shift counter
//
// univ_shift_reg_stage: one D-type bit with clock enable and synchronous reset.
//   CK      rising-edge clock
//   RN      synchronous reset, active-low (loads RST_BIT)
//   EN      capture enable
//   D       next bit value
//   Q / QP  true and complement outputs
//
// univ_shift_reg: WIDTH-bit hold / shift right / shift left / load register.
//   CK, RN  clock and synchronous active-low reset (RN overrides EN and MODE)
//   EN      clock enable, 0 holds Q and CNT
//   MODE    00 hold, 01 shift right, 10 shift left, 11 parallel load
//   ROT     rotate on shifts instead of taking the serial inputs
//   SIR     serial input entering the MSB on shift right
//   SIL     serial input entering the LSB on shift left
//   D       parallel load data
//   Q / QP  register contents and complement
//   SOR     Q[0], bit leaving on a right shift
//   SOL     Q[WIDTH-1], bit leaving on a left shift
//   CNT     shifts since last load/reset, saturating at WIDTH
//   WFULL   CNT == WIDTH, a complete serial word has entered

module univ_shift_reg_stage #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic CK,
  input  logic RN,
  input  logic EN,
  input  logic D,
  output logic Q,
  output logic QP
);

  always_ff @(posedge CK) begin
    if (!RN) begin
      Q <= RST_BIT;
    end else if (EN) begin
      Q <= D;
    end
  end

  assign QP = ~Q;

endmodule

module univ_shift_reg #(
  parameter int              WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                       CK,
  input  logic                       RN,
  input  logic                       EN,
  input  logic [1:0]                 MODE,
  input  logic                       ROT,
  input  logic                       SIR,
  input  logic                       SIL,
  input  logic [WIDTH-1:0]           D,
  output logic [WIDTH-1:0]           Q,
  output logic [WIDTH-1:0]           QP,
  output logic                       SOR,
  output logic                       SOL,
  output logic [$clog2(WIDTH+1)-1:0] CNT,
  output logic                       WFULL
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_RIGHT = 2'b01;
  localparam logic [1:0] MODE_LEFT  = 2'b10;
  localparam logic [1:0] MODE_LOAD  = 2'b11;

  logic [WIDTH-1:0] next_q;
  logic             fill_right;
  logic             fill_left;
  logic [CW-1:0]    next_cnt;

  // Rotation feeds back the bit that is about to fall off the other end.
  assign fill_right = ROT ? Q[0]       : SIR;
  assign fill_left  = ROT ? Q[WIDTH-1] : SIL;

  always_comb begin
    next_q = Q;
    case (MODE)
      MODE_RIGHT: next_q = {fill_right, Q[WIDTH-1:1]};
      MODE_LEFT:  next_q = {Q[WIDTH-2:0], fill_left};
      MODE_LOAD:  next_q = D;
      default:    next_q = Q;
    endcase
  end

  // Each bit only captures when EN is high, so nothing decoded from MODE or
  // the serial inputs can reach state while the register is disabled.
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    univ_shift_reg_stage #(
      .RST_BIT (RESET_VAL[i])
    ) u_stage (
      .CK (CK),
      .RN (RN),
      .EN (EN),
      .D  (next_q[i]),
      .Q  (Q[i]),
      .QP (QP[i])
    );
  end

  // Rotations count as shifts; the count stops at WIDTH instead of wrapping.
  always_comb begin
    next_cnt = CNT;
    case (MODE)
      MODE_RIGHT, MODE_LEFT: begin
        if (CNT != CW'(WIDTH)) begin
          next_cnt = CNT + CW'(1);
        end
      end
      MODE_LOAD: next_cnt = '0;
      MODE_HOLD: next_cnt = CNT;
      default:   next_cnt = CNT;
    endcase
  end

  always_ff @(posedge CK) begin
    if (!RN) begin
      CNT <= '0;
    end else if (EN) begin
      CNT <= next_cnt;
    end
  end

  assign SOR   = Q[0];
  assign SOL   = Q[WIDTH-1];
  assign WFULL = (CNT == CW'(WIDTH));

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - randomized self-checking bench for univ_shift_reg
module tb_univ_shift_reg;

  logic       clk;
  logic       rn4, en4, rot4, sir4, sil4;
  logic [1:0] mode4;
  logic [3:0] d4;
  logic [3:0] q4, qp4;
  logic       sor4, sol4, wfull4;
  logic [2:0] cnt4;

  logic       rn8, en8, rot8, sir8, sil8;
  logic [1:0] mode8;
  logic [7:0] d8;
  logic [7:0] q8, qp8;
  logic       sor8, sol8, wfull8;
  logic [3:0] cnt8;

  int checks = 0;
  int failures = 0;
  int m4, c4, m8, c8;

  univ_shift_reg #(.WIDTH(4), .RESET_VAL(4'h0)) dut4 (
    .CK(clk), .RN(rn4), .EN(en4), .MODE(mode4), .ROT(rot4), .SIR(sir4), .SIL(sil4),
    .D(d4), .Q(q4), .QP(qp4), .SOR(sor4), .SOL(sol4), .CNT(cnt4), .WFULL(wfull4)
  );

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5)) dut8 (
    .CK(clk), .RN(rn8), .EN(en8), .MODE(mode8), .ROT(rot8), .SIR(sir8), .SIL(sil8),
    .D(d8), .Q(q8), .QP(qp8), .SOR(sor8), .SOL(sol8), .CNT(cnt8), .WFULL(wfull8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register value as an integer: a right shift halves it and puts the fill
  // bit at weight 2^(w-1); a left shift doubles it and adds the fill bit.
  function automatic int ref_next(int w, int q, logic [1:0] mode, logic rot,
                                  logic sir, logic sil, int d);
    int mask;
    int fill;
    mask = (1 << w) - 1;
    case (mode)
      2'b01: begin
        fill = rot ? (q % 2) : int'(sir);
        return ((q / 2) + fill * (1 << (w - 1))) & mask;
      end
      2'b10: begin
        fill = rot ? ((q >> (w - 1)) % 2) : int'(sil);
        return (q * 2 + fill) & mask;
      end
      2'b11: return d & mask;
      default: return q;
    endcase
  endfunction

  function automatic int ref_cnt(int w, int c, logic [1:0] mode);
    if (mode == 2'b11) return 0;
    if (mode == 2'b01 || mode == 2'b10) return (c < w) ? c + 1 : w;
    return c;
  endfunction

  // Advance both models from the inputs currently driven, then take one edge.
  task automatic tick();
    if (!rn4) begin
      m4 = 0; c4 = 0;
    end else if (en4) begin
      c4 = ref_cnt(4, c4, mode4);
      m4 = ref_next(4, m4, mode4, rot4, sir4, sil4, int'(d4));
    end
    if (!rn8) begin
      m8 = 32'hA5; c8 = 0;
    end else if (en8) begin
      c8 = ref_cnt(8, c8, mode8);
      m8 = ref_next(8, m8, mode8, rot8, sir8, sil8, int'(d8));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(logic en, logic [1:0] mode, logic rot, logic sir, logic [3:0] d);
    rn4 = 1'b1; en4 = en; mode4 = mode; rot4 = rot; sir4 = sir; sil4 = sir; d4 = d;
  endtask

  task automatic test_reset();
    rn4 = 1'b0; en4 = 1'b1; mode4 = 2'b11; d4 = 4'hF; rot4 = 0; sir4 = 1; sil4 = 1;
    rn8 = 1'b0; en8 = 1'b1; mode8 = 2'b11; d8 = 8'hFF; rot8 = 0; sir8 = 1; sil8 = 1;
    tick();
    checks++; if (q4 !== 4'b0000) begin failures++; $display("FAIL reset_q4 got=%h exp=0", q4); end
    checks++; if (qp4 !== 4'b1111) begin failures++; $display("FAIL reset_qp4 got=%h exp=f", qp4); end
    checks++; if (cnt4 !== 3'd0) begin failures++; $display("FAIL reset_cnt4 got=%0d exp=0", cnt4); end
    checks++; if (wfull4 !== 1'b0) begin failures++; $display("FAIL reset_wfull4 got=%b exp=0", wfull4); end
    checks++; if (q8 !== 8'hA5) begin failures++; $display("FAIL reset_q8 got=%h exp=a5", q8); end
    checks++; if (qp8 !== 8'h5A) begin failures++; $display("FAIL reset_qp8 got=%h exp=5a", qp8); end
    rn8 = 1'b1; en8 = 1'b0;
  endtask

  task automatic test_load_hold();
    drive4(1'b1, 2'b11, 1'b0, 1'b0, 4'b1010);
    tick();
    checks++; if (q4 !== 4'b1010) begin failures++; $display("FAIL load_q got=%b exp=1010", q4); end
    for (int i = 0; i < 3; i++) begin
      drive4(1'b1, 2'b00, 1'b0, i[0], 4'b0101);
      tick();
      checks++; if (q4 !== 4'b1010 || cnt4 !== 3'd0) begin
        failures++; $display("FAIL hold_%0d got q=%b cnt=%0d exp q=1010 cnt=0", i, q4, cnt4);
      end
    end
  endtask

  task automatic test_shift_right_fill();
    logic [3:0] exp_q [4];
    exp_q = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
    drive4(1'b1, 2'b11, 1'b0, 1'b0, 4'b0000);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive4(1'b1, 2'b01, 1'b0, 1'b1, 4'b0000);
      tick();
      checks++; if (q4 !== exp_q[i] || cnt4 !== 3'(i + 1) || wfull4 !== (i == 3)) begin
        failures++;
        $display("FAIL shr_%0d got q=%b cnt=%0d wfull=%b exp q=%b cnt=%0d wfull=%b",
                 i, q4, cnt4, wfull4, exp_q[i], i + 1, (i == 3));
      end
    end
    drive4(1'b1, 2'b01, 1'b0, 1'b1, 4'b0000);
    tick();
    checks++; if (cnt4 !== 3'd4 || wfull4 !== 1'b1) begin
      failures++; $display("FAIL shr_saturate got cnt=%0d wfull=%b exp cnt=4 wfull=1", cnt4, wfull4);
    end
  endtask

  task automatic test_rotate_left();
    logic [3:0] exp_q [2];
    exp_q = '{4'b0011, 4'b0110};
    drive4(1'b1, 2'b11, 1'b0, 1'b0, 4'b1001);
    tick();
    checks++; if (sol4 !== 1'b1) begin failures++; $display("FAIL rotl_sol_load got=%b exp=1", sol4); end
    for (int i = 0; i < 2; i++) begin
      drive4(1'b1, 2'b10, 1'b1, 1'b0, 4'b0000);
      tick();
      checks++; if (q4 !== exp_q[i] || sol4 !== 1'b0 || sor4 !== exp_q[i][0]) begin
        failures++; $display("FAIL rotl_%0d got q=%b sol=%b sor=%b exp q=%b", i, q4, sol4, sor4, exp_q[i]);
      end
    end
    checks++; if (cnt4 !== 3'd2) begin failures++; $display("FAIL rotl_cnt got=%0d exp=2", cnt4); end
  endtask

  task automatic test_enable_hold();
    drive4(1'b1, 2'b11, 1'b0, 1'b0, 4'b0001);
    tick();
    drive4(1'b1, 2'b01, 1'b1, 1'b0, 4'b0000);
    tick();
    checks++; if (q4 !== 4'b1000 || cnt4 !== 3'd1) begin
      failures++; $display("FAIL rotr got q=%b cnt=%0d exp q=1000 cnt=1", q4, cnt4);
    end
    for (int i = 0; i < 6; i++) begin
      drive4(1'b0, 2'($urandom), 1'($urandom), 1'($urandom), 4'($urandom));
      sil4 = 1'($urandom);
      tick();
      checks++; if (q4 !== 4'b1000 || cnt4 !== 3'd1) begin
        failures++; $display("FAIL en_hold_%0d got q=%b cnt=%0d exp q=1000 cnt=1", i, q4, cnt4);
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    drive4(1'b1, 2'b11, 1'b0, 1'b0, 4'b0110);
    rn8 = 1'b1; en8 = 1'b1; mode8 = 2'b11; d8 = 8'h3C; rot8 = 0; sir8 = 1; sil8 = 0;
    tick();
    for (int i = 0; i < 2; i++) begin
      drive4(1'b1, 2'b10, 1'b0, 1'b1, 4'b0000);
      mode8 = 2'b01;
      tick();
    end
    checks++; if (cnt4 !== 3'd2 || cnt8 !== 4'd2) begin
      failures++; $display("FAIL mid_cnt got cnt4=%0d cnt8=%0d exp 2 2", cnt4, cnt8);
    end
    rn4 = 1'b0; rn8 = 1'b0;
    tick();
    checks++; if (q4 !== 4'b0000 || cnt4 !== 3'd0 || wfull4 !== 1'b0) begin
      failures++; $display("FAIL mid_rst4 got q=%b cnt=%0d wfull=%b exp 0000 0 0", q4, cnt4, wfull4);
    end
    checks++; if (q8 !== 8'hA5 || qp8 !== 8'h5A || cnt8 !== 4'd0) begin
      failures++; $display("FAIL mid_rst8 got q=%h qp=%h cnt=%0d exp a5 5a 0", q8, qp8, cnt8);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rn4 = ($urandom_range(0, 24) != 0); en4 = ($urandom_range(0, 4) != 0);
      mode4 = 2'($urandom); rot4 = 1'($urandom); sir4 = 1'($urandom);
      sil4 = 1'($urandom); d4 = 4'($urandom);
      rn8 = ($urandom_range(0, 24) != 0); en8 = ($urandom_range(0, 4) != 0);
      mode8 = 2'($urandom); rot8 = 1'($urandom); sir8 = 1'($urandom);
      sil8 = 1'($urandom); d8 = 8'($urandom);
      tick();
      checks++;
      if (q4 !== 4'(m4) || qp4 !== ~4'(m4) || cnt4 !== 3'(c4) || wfull4 !== (c4 == 4) ||
          sor4 !== 1'(m4 % 2) || sol4 !== 1'((m4 >> 3) % 2)) begin
        failures++;
        $display("FAIL rand4_%0d got q=%h qp=%h cnt=%0d wfull=%b exp q=%h cnt=%0d",
                 i, q4, qp4, cnt4, wfull4, 4'(m4), c4);
      end
      checks++;
      if (q8 !== 8'(m8) || qp8 !== ~8'(m8) || cnt8 !== 4'(c8) || wfull8 !== (c8 == 8) ||
          sor8 !== 1'(m8 % 2) || sol8 !== 1'((m8 >> 7) % 2)) begin
        failures++;
        $display("FAIL rand8_%0d got q=%h qp=%h cnt=%0d wfull=%b exp q=%h cnt=%0d",
                 i, q8, qp8, cnt8, wfull8, 8'(m8), c8);
      end
    end
  endtask

  initial begin
    m4 = 0; c4 = 0; m8 = 32'hA5; c8 = 0;
    #2;
    test_reset();
    test_load_hold();
    test_shift_right_fill();
    test_rotate_left();
    test_enable_hold();
    test_reset_mid_shift();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
